// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants for the FIFO read-side first-word-fall-through stage.
package fifo_pkg;
    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int FWFT_DEPTH         = 2;
    localparam int LEVEL_W            = 2;
    localparam int WORD_CNT_W         = 16;
endpackage

// File: rtl/fwft_buf2.sv
// fwft_buf2: two-entry register store with head/tail pointers and occupancy count.
module fwft_buf2
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [LEVEL_W-1:0]    o_count
);
    logic [DATA_WIDTH-1:0] r_mem [FWFT_DEPTH];
    logic                  r_head;
    logic                  r_tail;
    logic [LEVEL_W-1:0]    r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_head   <= 1'b0;
            r_tail   <= 1'b0;
            r_count  <= '0;
        end else begin
            if (i_wr) begin
                r_mem[r_tail] <= i_wr_data;
                r_tail        <= ~r_tail;
            end
            if (i_rd)
                r_head <= ~r_head;
            r_count <= r_count + LEVEL_W'(i_wr) - LEVEL_W'(i_rd);
        end
    end

    assign o_data  = r_mem[r_head];
    assign o_count = r_count;
endmodule

// File: rtl/fifo_rd_fwft.sv
// fifo_rd_fwft: credit-based read issue into a 2-entry FWFT output buffer.
// Define FIFO_RD_FWFT_CNT_EN to add the o_word_cnt delivered-word counter.
module fifo_rd_fwft
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  i_rd_clk,
    input  logic                  i_rst_n,
    input  logic                  i_empty_flag,
    output logic                  o_rd_en,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [LEVEL_W-1:0]    o_level
`ifdef FIFO_RD_FWFT_CNT_EN
    ,
    output logic [WORD_CNT_W-1:0] o_word_cnt
`endif
);
    logic               r_inflight;
    logic               w_pop;
    logic [LEVEL_W-1:0] w_count;
    logic [LEVEL_W:0]   w_credit;

    assign w_pop = o_valid && i_ready;
    // Slots held or already promised, after this cycle's pop frees one.
    assign w_credit = {1'b0, w_count} + {{LEVEL_W{1'b0}}, r_inflight} - {{LEVEL_W{1'b0}}, w_pop};
    assign o_rd_en  = !i_empty_flag && (w_credit < (LEVEL_W+1)'(FWFT_DEPTH));

    always_ff @(posedge i_rd_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_inflight <= 1'b0;
        else
            r_inflight <= o_rd_en;
    end

    fwft_buf2 #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
        .i_clk     (i_rd_clk),
        .i_rst_n   (i_rst_n),
        .i_wr      (r_inflight),
        .i_wr_data (i_rd_data),
        .i_rd      (w_pop),
        .o_data    (o_data),
        .o_count   (w_count)
    );

    assign o_valid = (w_count != '0);
    assign o_level = w_count;

`ifdef FIFO_RD_FWFT_CNT_EN
    logic [WORD_CNT_W-1:0] r_word_cnt;

    always_ff @(posedge i_rd_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_word_cnt <= '0;
        else if (w_pop)
            r_word_cnt <= r_word_cnt + 1'b1;
    end

    assign o_word_cnt = r_word_cnt;
`endif
endmodule

// File: tb/tb_fifo_rd_fwft.sv
// tb_fifo_rd_fwft: directed tests with a behavioural pointer/memory model upstream.
module tb_fifo_rd_fwft;
    logic       i_rd_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_empty_flag = 1'b1;
    logic       o_rd_en;
    logic [7:0] i_rd_data = 8'hEE;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready = 1'b0;
    logic [1:0] o_level;
`ifdef FIFO_RD_FWFT_CNT_EN
    logic [15:0] o_word_cnt;
`endif

    int n_assert = 0;
    int n_fail = 0;
    logic [7:0] mem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;
    logic s_valid, s_rd_en, prev_en;
    logic [7:0] s_data;
    logic [1:0] s_level;

    always #5 i_rd_clk = ~i_rd_clk;

    fifo_rd_fwft #(.DATA_WIDTH(8)) dut (
        .i_rd_clk     (i_rd_clk),
        .i_rst_n      (i_rst_n),
        .i_empty_flag (i_empty_flag),
        .o_rd_en      (o_rd_en),
        .i_rd_data    (i_rd_data),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_level      (o_level)
`ifdef FIFO_RD_FWFT_CNT_EN
        ,
        .o_word_cnt   (o_word_cnt)
`endif
    );

    always @(posedge i_rd_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            prev_en <= 1'b0;
        else
            prev_en <= o_rd_en;
    end

    always @(negedge i_rd_clk) begin
        if (i_rst_n) begin
            n_assert++;
            if (o_rd_en && i_empty_flag) begin
                n_fail++;
                $display("FAIL rd_en_while_empty: o_rd_en=%b with i_empty_flag=%b", o_rd_en, i_empty_flag);
            end
            n_assert++;
            if (int'(o_level) + int'(prev_en) > 2) begin
                n_fail++;
                $display("FAIL credit_overflow: level=%0d inflight=%0d, sum must be <=2", o_level, prev_en);
            end
        end
    end

    task automatic push(input logic [7:0] d);
        mem[wr_ptr] = d;
        wr_ptr++;
        i_empty_flag = (rd_ptr >= wr_ptr);
    endtask

    // Sample outputs mid-cycle, then advance one clock and model the pointer block.
    task automatic tick;
        #1;
        s_valid = o_valid;
        s_data  = o_data;
        s_rd_en = o_rd_en;
        s_level = o_level;
        @(posedge i_rd_clk);
        #1;
        if (s_rd_en) begin
            i_rd_data = mem[rd_ptr];
            rd_ptr++;
        end else
            i_rd_data = 8'hEE;
        i_empty_flag = (rd_ptr >= wr_ptr);
    endtask

    task automatic test_reset;
        i_rst_n = 1'b0;
        repeat (2) @(posedge i_rd_clk);
        #2;
        n_assert++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        n_assert++;
        if (o_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", o_data); end
        n_assert++;
        if (o_level !== 2'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", o_level); end
        n_assert++;
        if (o_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", o_rd_en); end
        @(negedge i_rd_clk);
        i_rst_n = 1'b1;
        @(posedge i_rd_clk);
        #1;
        tick;
        tick;
        n_assert++;
        if (s_valid !== 1'b0 || s_rd_en !== 1'b0 || s_level !== 2'd0) begin
            n_fail++;
            $display("FAIL idle_empty: valid=%b rd_en=%b level=%0d want 0/0/0", s_valid, s_rd_en, s_level);
        end
    endtask

    task automatic test_single;
        i_ready = 1'b1;
        push(8'hA5);
        tick;
        n_assert++;
        if (s_rd_en !== 1'b1 || s_valid !== 1'b0) begin n_fail++; $display("FAIL single_n: rd_en=%b valid=%b want 1/0", s_rd_en, s_valid); end
        tick;
        n_assert++;
        if (s_rd_en !== 1'b0 || s_valid !== 1'b0) begin n_fail++; $display("FAIL single_n1: rd_en=%b valid=%b want 0/0", s_rd_en, s_valid); end
        tick;
        n_assert++;
        if (s_valid !== 1'b1 || s_data !== 8'hA5) begin n_fail++; $display("FAIL single_n2: valid=%b data=%h want 1/a5", s_valid, s_data); end
        tick;
        n_assert++;
        if (s_valid !== 1'b0) begin n_fail++; $display("FAIL single_n3: valid=%b want 0", s_valid); end
    endtask

    task automatic test_stream;
        i_ready = 1'b1;
        for (int k = 0; k < 16; k++) push(8'(k));
        tick;
        tick;
        n_assert++;
        if (s_valid !== 1'b0) begin n_fail++; $display("FAIL stream_latency: valid=%b at N+1 want 0", s_valid); end
        for (int k = 0; k < 16; k++) begin
            tick;
            n_assert++;
            if (s_valid !== 1'b1 || s_data !== 8'(k) || s_level !== 2'd1) begin
                n_fail++;
                $display("FAIL stream_word%0d: valid=%b data=%h level=%0d want 1/%h/1", k, s_valid, s_data, s_level, 8'(k));
            end
        end
        tick;
        n_assert++;
        if (s_valid !== 1'b0) begin n_fail++; $display("FAIL stream_end: valid=%b want 0", s_valid); end
    endtask

    task automatic test_stall;
        int n_rd;
        int got;
        i_ready = 1'b0;
        n_rd = 0;
        for (int k = 0; k < 8; k++) push(8'(k));
        for (int c = 0; c < 8; c++) begin
            tick;
            if (s_rd_en) n_rd++;
        end
        n_assert++;
        if (n_rd !== 2) begin n_fail++; $display("FAIL stall_reads: got %0d pulses want 2", n_rd); end
        tick;
        n_assert++;
        if (s_level !== 2'd2 || s_valid !== 1'b1 || s_data !== 8'h00) begin
            n_fail++;
            $display("FAIL stall_hold: level=%0d valid=%b data=%h want 2/1/00", s_level, s_valid, s_data);
        end
        i_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            tick;
            if (s_valid) begin
                n_assert++;
                if (s_data !== 8'(got)) begin n_fail++; $display("FAIL stall_word%0d: got %h want %h", got, s_data, 8'(got)); end
                got++;
            end
        end
        n_assert++;
        if (got !== 8) begin n_fail++; $display("FAIL stall_count: got %0d words want 8", got); end
        tick;
        n_assert++;
        if (s_valid !== 1'b0) begin n_fail++; $display("FAIL stall_end: valid=%b want 0", s_valid); end
    endtask

    task automatic test_random;
        int base;
        int pushed;
        int got;
        base = wr_ptr;
        pushed = 0;
        got = 0;
        for (int c = 0; c < 4000 && got < 256; c++) begin
            if (pushed < 256 && $urandom_range(0, 1) == 1) begin
                push(8'($urandom_range(0, 255)));
                pushed++;
            end
            i_ready = ($urandom_range(0, 1) == 1);
            tick;
            if (s_valid && i_ready) begin
                n_assert++;
                if (s_data !== mem[base+got]) begin n_fail++; $display("FAIL random_word%0d: got %h want %h", got, s_data, mem[base+got]); end
                got++;
            end
        end
        n_assert++;
        if (got !== 256) begin n_fail++; $display("FAIL random_count: got %0d words want 256", got); end
        i_ready = 1'b1;
        tick;
        tick;
        n_assert++;
        if (s_valid !== 1'b0) begin n_fail++; $display("FAIL random_extra: valid=%b want 0 (duplicate or extra word)", s_valid); end
`ifdef FIFO_RD_FWFT_CNT_EN
        n_assert++;
        if (o_word_cnt !== 16'd281) begin n_fail++; $display("FAIL word_cnt_total: got %0d want 281", o_word_cnt); end
`endif
    endtask

    task automatic test_reset_mid;
        i_ready = 1'b0;
        push(8'h11);
        push(8'h22);
        tick;
        tick;
        #1;
        n_assert++;
        if (o_level !== 2'd1 || prev_en !== 1'b1) begin n_fail++; $display("FAIL mid_setup: level=%0d inflight=%b want 1/1", o_level, prev_en); end
        #1;
        i_rst_n = 1'b0;
        rd_ptr = 0;
        wr_ptr = 0;
        i_empty_flag = 1'b1;
        i_rd_data = 8'hEE;
        #1;
        n_assert++;
        if (o_valid !== 1'b0 || o_data !== 8'h00 || o_level !== 2'd0 || o_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: valid=%b data=%h level=%0d rd_en=%b want 0/00/0/0", o_valid, o_data, o_level, o_rd_en);
        end
`ifdef FIFO_RD_FWFT_CNT_EN
        n_assert++;
        if (o_word_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_reset_cnt: got %0d want 0", o_word_cnt); end
`endif
        @(posedge i_rd_clk);
        #3;
        i_rst_n = 1'b1;
        @(posedge i_rd_clk);
        #1;
        i_ready = 1'b1;
        push(8'h3C);
        tick;
        tick;
        tick;
        n_assert++;
        if (s_valid !== 1'b1 || s_data !== 8'h3C) begin n_fail++; $display("FAIL mid_after: valid=%b data=%h want 1/3c", s_valid, s_data); end
`ifdef FIFO_RD_FWFT_CNT_EN
        #1;
        n_assert++;
        if (o_word_cnt !== 16'd1) begin n_fail++; $display("FAIL mid_after_cnt: got %0d want 1", o_word_cnt); end
`endif
        tick;
        n_assert++;
        if (s_valid !== 1'b0) begin n_fail++; $display("FAIL mid_after_end: valid=%b want 0", s_valid); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_stream;
        test_stall;
        test_random;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_rd_fwft.md
# fifo_rd_fwft

Read-side output stage for the asynchronous FIFO, placed directly downstream of the read-pointer/empty-flag logic in the read clock domain. Issues read enables to the pointer block, captures the one-cycle-latency memory read data, and presents it as a first-word-fall-through valid/ready stream. A two-entry output buffer with credit-based issue sustains one word per cycle under continuous `i_ready`.

## Interface
- `DATA_WIDTH`, 8, width of the FIFO data word
- `i_rd_clk`  input  1  read-domain clock, all logic on rising edge
- `i_rst_n`  input  1  asynchronous active-low reset
- `i_empty_flag`  input  1  empty flag from read-pointer block
- `o_rd_en`  output  1  read enable to read-pointer block and memory
- `i_rd_data`  input  DATA_WIDTH  memory read data, valid the cycle after an accepted `o_rd_en`
- `o_data`  output  DATA_WIDTH  head word of output buffer
- `o_valid`  output  1  `o_data` holds a valid word
- `i_ready`  input  1  consumer accepts `o_data` this cycle
- `o_level`  output  2  words held in output buffer (0..2)
- `o_word_cnt`  output  16  delivered-word counter (only with `FIFO_RD_FWFT_CNT_EN`)

## Operation
- State: 2-entry buffer `buf[0:1]`, 1-bit head/tail pointers, 2-bit `count`, 1-bit `inflight`.
- Pop: `pop = o_valid && i_ready`; advances head, `count-1`.
- Issue: `o_rd_en = !i_empty_flag && (count + inflight - pop) < 2`. Never asserted while `i_empty_flag` is high, so every `o_rd_en` high is an accepted read.
- `inflight` register = `o_rd_en` of the previous cycle.
- Capture: when `inflight` is 1, `i_rd_data` is written to `buf[tail]`, tail advances, `count+1`.
- Capture and pop in the same cycle: count unchanged, head and tail both advance.
- `o_valid = (count != 0)`, `o_data = buf[head]`, `o_level = count`.
- Order preserved: words leave in memory-address order, no drops, no duplicates.
- Overflow impossible by construction: `count + inflight` never exceeds 2. Capture with `count == 2` is a design error.
- `o_data` holds its value while `o_valid && !i_ready`. It is stable, not re-read.

## Timing
- Reset (async, immediate): `count=0`, `inflight=0`, pointers 0, `buf` cleared to 0. Result: `o_valid=0`, `o_data=0`, `o_level=0`, `o_word_cnt=0`.
- `o_rd_en` is combinational from `i_empty_flag`, `i_ready` and registered state. Path `i_ready -> o_rd_en` is accepted.
- Latency: `i_empty_flag` falls in cycle N gives `o_rd_en` high in N, capture at the end of N+1, `o_valid` high in N+2.
- Throughput: with `i_ready` held high and FIFO non-empty, one word per cycle in steady state (`count=1`, `inflight=1`).
- `i_ready` low: at most 2 further reads issue, then `o_rd_en` stays low until a pop.
- Empty boundary: last word is issued, then `i_empty_flag` rises. The in-flight capture still completes.
- Reset mid-operation: in-flight read is discarded. The pointer block resets on the same `i_rst_n`, so no word is lost relative to the reset pointers.

## Configuration
- `FIFO_RD_FWFT_CNT_EN` defined: port `o_word_cnt` exists. It increments on every pop, wraps 0xFFFF to 0, resets to 0.
- Not defined: port and counter are absent. All other behaviour is identical.

## Structure
- Shared package `fifo_pkg`: default `DATA_WIDTH`, buffer depth constant `FWFT_DEPTH=2`, `LEVEL_W=2`, `WORD_CNT_W=16`.
- One sub-module: `fwft_buf2`, the two-entry register store with head/tail and count. The top level holds issue/credit logic, the `inflight` register, and the optional counter.

## Test plan
- Reset, then FIFO empty: `o_valid=0`, `o_rd_en=0`, `o_level=0`, `o_data=0`.
- Single word 0xA5 written, empty falls cycle N, `i_ready=1`: `o_rd_en` pulses once in N, `o_valid` with 0xA5 in N+2 for exactly one cycle.
- 16 words 0..15, `i_ready=1` throughout: 16 consecutive valid cycles, data 0..15 in order, no gaps after first.
- 8 words, `i_ready=0`: exactly 2 `o_rd_en` pulses, `o_level=2`, `o_data=0` held. Then `i_ready=1`: words 0..7 delivered in order, no duplicates.
- Random `i_ready` (50%) over 256 words: output sequence matches input. Assert `o_rd_en` never high with `i_empty_flag` high, and `count+inflight<=2`.
- `i_rst_n` low with `inflight=1` and `o_level=1`: outputs zero immediately. After release, a new word 0x3C is delivered correctly. With `FIFO_RD_FWFT_CNT_EN`, `o_word_cnt` returns to 0 and counts from 0.
